// File: rtl/debug_unit_param.sv
// debug_unit_param: UART-side debug controller for the MIPS core.
// Loads instruction RAM from host bytes, runs the core freely or one step
// at a time, and streams DUMP_WORDS debug words back to the host.
module debug_unit_param #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 11,
    parameter int                DUMP_WORDS = 4,
    parameter logic [DATA_W-1:0] HALT_WORD  = {DATA_W{1'b1}},
    localparam int               SEL_W      = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data_in,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [7:0]        data_out,
    input  logic              halt,
    input  logic [DATA_W-1:0] dump_data,
    output logic [SEL_W-1:0]  dump_sel,
    output logic [ADDR_W-1:0] addr_mem_inst,
    output logic [DATA_W-1:0] ins_to_mem,
    output logic              wr_ram_inst,
    output logic              ctrl_clk_mips,
    output logic              debug,
    output logic              load_done
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(DUMP_WORDS - 1);

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_NEXT = 8'h04;
    localparam logic [7:0] CMD_EXIT = 8'h05;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD       = 4'd1;
    localparam logic [3:0] S_WRITE      = 4'd2;
    localparam logic [3:0] S_RUN        = 4'd3;
    localparam logic [3:0] S_STEP_WAIT  = 4'd4;
    localparam logic [3:0] S_STEP_EXEC  = 4'd5;
    localparam logic [3:0] S_DUMP_SEL   = 4'd6;
    localparam logic [3:0] S_DUMP_LATCH = 4'd7;
    localparam logic [3:0] S_DUMP_TX    = 4'd8;
    localparam logic [3:0] S_DUMP_WAIT  = 4'd9;

    logic [3:0]        r_state;
    logic              r_rx_d;
    logic              r_rx_dd;
    logic [7:0]        r_rx_data;
    logic              r_tx_d;
    logic              r_tx_dd;
    logic [BCNT_W-1:0] r_byte;
    logic [DATA_W-1:0] r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dump_word;
    logic [SEL_W-1:0]  r_dump_sel;
    logic [7:0]        r_data_out;
    logic              r_tx_start;
    logic              r_from_run;

    logic w_rx_evt;
    logic w_tx_evt;
    logic w_load_end;

    // A tick counts once, on the rising edge of its registered copy.
    assign w_rx_evt   = r_rx_d & ~r_rx_dd;
    assign w_tx_evt   = r_tx_d & ~r_tx_dd;
    // A load ends on the halt word or when the last RAM address was written.
    assign w_load_end = (r_word == HALT_WORD) || (&r_addr);

    // Main control FSM with tick edge detection and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rx_d      <= 1'b0;
            r_rx_dd     <= 1'b0;
            r_rx_data   <= 8'h00;
            r_tx_d      <= 1'b0;
            r_tx_dd     <= 1'b0;
            r_byte      <= '0;
            r_word      <= '0;
            r_addr      <= '0;
            r_dump_word <= '0;
            r_dump_sel  <= '0;
            r_data_out  <= 8'h00;
            r_tx_start  <= 1'b0;
            r_from_run  <= 1'b0;
        end else begin
            r_rx_d     <= rx_done_tick;
            r_rx_dd    <= r_rx_d;
            r_rx_data  <= rx_data_in;
            r_tx_d     <= tx_done_tick;
            r_tx_dd    <= r_tx_d;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_evt) begin
                        case (r_rx_data)
                            CMD_LOAD: begin
                                r_byte  <= '0;
                                r_state <= S_LOAD;
                            end
                            CMD_RUN:  r_state <= S_RUN;
                            CMD_STEP: r_state <= S_STEP_WAIT;
                            default:  r_state <= S_IDLE;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (w_rx_evt) begin
                        r_word[{r_byte, 3'b000} +: 8] <= r_rx_data;
                        if (r_byte == LAST_BYTE) begin
                            r_byte  <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_byte <= r_byte + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_load_end) begin
                        r_addr  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        r_from_run <= 1'b1;
                        r_dump_sel <= '0;
                        r_state    <= S_DUMP_SEL;
                    end
                end
                S_STEP_WAIT: begin
                    if (w_rx_evt) begin
                        if (r_rx_data == CMD_NEXT) begin
                            r_state <= S_STEP_EXEC;
                        end else if (r_rx_data == CMD_EXIT) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_STEP_WAIT;
                        end
                    end
                end
                S_STEP_EXEC: begin
                    r_from_run <= 1'b0;
                    r_dump_sel <= '0;
                    r_state    <= S_DUMP_SEL;
                end
                S_DUMP_SEL: begin
                    // dump_sel is stable this cycle; dump_data is valid next.
                    r_state <= S_DUMP_LATCH;
                end
                S_DUMP_LATCH: begin
                    r_dump_word <= dump_data;
                    r_byte      <= '0;
                    r_state     <= S_DUMP_TX;
                end
                S_DUMP_TX: begin
                    r_data_out <= r_dump_word[{r_byte, 3'b000} +: 8];
                    r_tx_start <= 1'b1;
                    r_state    <= S_DUMP_WAIT;
                end
                S_DUMP_WAIT: begin
                    if (w_tx_evt) begin
                        if (r_byte == LAST_BYTE) begin
                            r_byte <= '0;
                            if (r_dump_sel == LAST_SEL) begin
                                r_dump_sel <= '0;
                                r_state    <= (r_from_run || halt) ? S_IDLE : S_STEP_WAIT;
                            end else begin
                                r_dump_sel <= r_dump_sel + 1'b1;
                                r_state    <= S_DUMP_SEL;
                            end
                        end else begin
                            r_byte  <= r_byte + 1'b1;
                            r_state <= S_DUMP_TX;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The core clock enable drops in the same cycle halt rises.
    assign ctrl_clk_mips = ((r_state == S_RUN) && !halt) || (r_state == S_STEP_EXEC);
    assign debug         = (r_state != S_RUN);
    assign wr_ram_inst   = (r_state == S_WRITE);
    assign load_done     = (r_state == S_WRITE) && w_load_end;
    assign ins_to_mem    = r_word;
    assign addr_mem_inst = r_addr;
    assign tx_start      = r_tx_start;
    assign data_out      = r_data_out;
    assign dump_sel      = r_dump_sel;

endmodule
